// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Optional subtract mode (a - b as a + ~b + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;

  // Subtraction inverts b at load time and seeds the carry with 1.
  logic load_inv;
`ifdef SERIAL_ADDER_SUB_EN
  assign load_inv = sub;
`else
  assign load_inv = 1'b0;
`endif

  // Full adder built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;
  assign ha1_s = a_sr[0] ^ b_sr[0];
  assign ha1_c = a_sr[0] & b_sr[0];
  assign fa_s  = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign fa_c  = ha1_c | ha2_c;

  // The oldest result bit drops out of res; the final sum is the new bit on top of res.
  logic [WIDTH-1:0] res_next;
  assign res_next = {fa_s, res};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{load_inv}};
            carry <= load_inv;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= fa_c;
          res   <= res_next[WIDTH-1:1];
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_next;
            cout  <= fa_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes arithmetic expectations,
// a negedge monitor pops and checks them whenever done is seen.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;
  int           run_len = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic; subtraction reports "no borrow" as cout.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic isub, input int due);
    exp_t e;
    int   full;
    if (isub) begin
      e.sum  = W'(int'(ia) - int'(ib));
      e.cout = (ia >= ib);
    end else begin
      full   = int'(ia) + int'(ib);
      e.sum  = W'(full);
      e.cout = (full >= (1 << W));
    end
    e.due = due;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      run_len = 0;
    end else begin
      exp_t e;
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy) run_len++;
      if (done) begin
        check("busy_length", 32'(run_len), 32'(W));
        run_len = 0;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 with sum=%0h, expected no pending result (cycle %0d)",
                   sum, cyc);
        end else begin
          e = sb.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("cout", 32'(cout), 32'(e.cout));
          check("latency", 32'(cyc), 32'(e.due));
          hold_sum  = e.sum;
          hold_cout = e.cout;
        end
      end else begin
        check("sum_hold", 32'(sum), 32'(hold_sum));
        check("cout_hold", 32'(cout), 32'(hold_cout));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    sb.push_back(model(ia, ib, isub, cyc + W + 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 * W; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    issue(ia, ib, isub);
    tick();
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    logic [W-1:0] ra, rb;
    logic rs;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Basic add, overflow, zero
    run_op(8'h5A, 8'h33, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h00, 8'h00, 1'b0);

    // start re-pulsed with new operands mid-RUN must be ignored
    issue(8'h01, 8'h01, 1'b0);
    tick();
    start = 1'b0;
    repeat (2) tick();
    a     = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'h00;
    wait_done();
    repeat (W + 2) tick();

    // start held high through DONE: back-to-back without IDLE
    p = cyc;
    issue(8'hC8, 8'h64, 1'b0);
    tick();
    a = 8'h7F;
    b = 8'h80;
    sb.push_back(model(8'h7F, 8'h80, 1'b0, p + 2 * W + 2));
    repeat (W + 1) tick();
    start = 1'b0;
    a     = 8'h55;
    wait_done();

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b1);
    run_op(8'h01, 8'h02, 1'b1);
    run_op(8'h80, 8'h80, 1'b1);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the 4th RUN cycle aborts; no done afterwards
    run_op(8'hAA, 8'h11, 1'b0);
    issue(8'h3C, 8'h2F, 1'b0);
    tick();
    start = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    rst_n     = 1'b1;
    hold_sum  = '0;
    hold_cout = 1'b0;
    mon_en    = 1'b1;
    repeat (2 * W) tick();

    // Recovery after abort
    run_op(8'h80, 8'h80, 1'b0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
